// File: rtl/led_matrix_capture_if.sv
// led_matrix_capture_if: LED matrix scan pins (row select plus red/green column data)
interface led_matrix_capture_if;
    logic [7:0] row_sink;
    logic [7:0] red_driver;
    logic [7:0] green_driver;
    modport master (output row_sink, red_driver, green_driver);
    modport slave (input row_sink, red_driver, green_driver);
endinterface

// File: rtl/led_matrix_capture.sv
// led_matrix_capture: rebuilds committed 8x8 red/green frames from a sampled LED matrix row scan
module led_matrix_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    led_matrix_capture_if.slave    scan,
    output logic [7:0][7:0]        red_array,
    output logic [7:0][7:0]        green_array,
    output logic                   frame_valid,
    output logic                   seq_error,
    output logic                   link_lost,
    output logic [CNT_W-1:0]       frame_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // synchroniser powers up showing blanking so no bogus row is ever sampled
    localparam logic [23:0] IDLE = {8'hFF, 16'h0};
    typedef enum logic {HUNT, COLLECT} state_t;
    state_t state, state_n;
    logic [23:0] sync1, sync2, prev;
    logic [7:0] stable, rows, red, green;
    logic [TW-1:0] idle_cnt;
    logic [7:0][7:0] shadow_red, shadow_green;
    logic [2:0] expected, expected_n, r;
    logic same, sample, row_ev, malformed, timeout, commit, seq_n;

    assign {rows, red, green} = prev;
    assign same = sync2 == prev;
    assign sample = same && stable == 8'(STABLE_CYCLES - 1);
    assign row_ev = sample && $onehot(~rows);
    assign malformed = sample && rows != 8'hFF && !$onehot(~rows);
    assign timeout = !row_ev && idle_cnt == TW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (!rows[i]) r = 3'(i);
    end

    always_comb begin
        state_n = state;
        expected_n = expected;
        commit = 1'b0;
        seq_n = 1'b0;
        if (malformed) begin
            seq_n = 1'b1;
            state_n = HUNT;
        end else if (row_ev) begin
            if (state == HUNT) begin
                state_n = r == 3'd0 ? COLLECT : HUNT;
                expected_n = r == 3'd0 ? 3'd1 : expected;
            end else if (r == expected) begin
                expected_n = expected + 3'd1;
                commit = r == 3'd7;
            end else begin
                seq_n = 1'b1;
                state_n = r == 3'd0 ? COLLECT : HUNT;
                expected_n = r == 3'd0 ? 3'd1 : 3'd0;
            end
        end else if (timeout) begin
            state_n = HUNT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
            prev <= IDLE;
            stable <= '0;
            idle_cnt <= '0;
            state <= HUNT;
            expected <= '0;
            shadow_red <= '0;
            shadow_green <= '0;
            red_array <= '0;
            green_array <= '0;
            frame_valid <= 1'b0;
            seq_error <= 1'b0;
            link_lost <= 1'b0;
            frame_count <= '0;
        end else begin
            sync1 <= {scan.row_sink, scan.red_driver, scan.green_driver};
            sync2 <= sync1;
            prev <= sync2;
            stable <= !same ? 8'd0 : stable == 8'(STABLE_CYCLES) ? stable : stable + 8'd1;
            idle_cnt <= row_ev ? '0 : idle_cnt == TW'(TIMEOUT_CYCLES) ? idle_cnt : idle_cnt + TW'(1);
            link_lost <= row_ev ? 1'b0 : timeout ? 1'b1 : link_lost;
            state <= state_n;
            expected <= expected_n;
            frame_valid <= commit;
            seq_error <= seq_n;
            if (row_ev) begin
                shadow_red[r] <= red;
                shadow_green[r] <= green;
            end
            // row 7 is still in flight this cycle, so it is merged straight into the commit
            if (commit) begin
                red_array <= {red, shadow_red[6:0]};
                green_array <= {green, shadow_green[6:0]};
                frame_count <= frame_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_led_matrix_capture.sv
// tb_led_matrix_capture: directed and random scan sequences checked against an event-level frame model
module tb_led_matrix_capture;
    localparam int S = 4;
    localparam int T = 64;
    localparam int CW = 2;

    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;

    led_matrix_capture_if bus();
    logic [7:0][7:0] red_array, green_array;
    logic frame_valid, seq_error, link_lost;
    logic [CW-1:0] frame_count;

    led_matrix_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .scan(bus),
        .red_array(red_array), .green_array(green_array),
        .frame_valid(frame_valid), .seq_error(seq_error),
        .link_lost(link_lost), .frame_count(frame_count)
    );

    int cyc = 0;
    int fv_seen = 0;
    int se_seen = 0;
    int total = 0;
    int fails = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (frame_valid) fv_seen++;
        if (seq_error) se_seen++;
    end

    // model: got = rows collected so far in the current frame, -1 while hunting
    logic [7:0][7:0] m_red, m_green, sh_red, sh_green;
    int m_count, m_fv, m_se, got, last_ev;
    logic [23:0] last_pat;
    int wrap_exp [5] = '{1, 2, 3, 0, 1};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset;
        m_red = '0; m_green = '0; sh_red = '0; sh_green = '0;
        m_count = 0; got = -1; last_ev = cyc; last_pat = {8'hFF, 16'h0};
    endtask

    task automatic drive(input logic [7:0] rs, input logic [7:0] rd, input logic [7:0] gr, input bit accepted);
        int e, r, zeros;
        bus.row_sink = rs; bus.red_driver = rd; bus.green_driver = gr;
        last_pat = {rs, rd, gr};
        if (!accepted || rs == 8'hFF) return;
        zeros = 0; r = 0;
        for (int i = 0; i < 8; i++) if (!rs[i]) begin zeros++; r = i; end
        if (zeros != 1) begin m_se++; got = -1; return; end
        e = cyc + S + 3;
        if (e > last_ev + T) got = -1;
        last_ev = e;
        sh_red[r] = rd; sh_green[r] = gr;
        if (got < 0) begin
            if (r == 0) got = 1;
        end else if (r == got) begin
            got++;
            if (got == 8) begin
                m_red = sh_red; m_green = sh_green;
                m_count = (m_count + 1) % (1 << CW); m_fv++; got = 0;
            end
        end else begin
            m_se++;
            got = (r == 0) ? 1 : -1;
        end
    endtask

    task automatic hold_check(input int n);
        repeat (n) @(posedge clk);
        #1;
        check("frame_valid pulses", 64'(fv_seen), 64'(m_fv));
        check("seq_error pulses", 64'(se_seen), 64'(m_se));
        check("link_lost", 64'(link_lost), 64'(cyc >= last_ev + T));
        check("frame_count", 64'(frame_count), 64'(m_count));
        check("red_array", red_array, m_red);
        check("green_array", green_array, m_green);
    endtask

    task automatic step(input logic [7:0] rs, input logic [7:0] rd, input logic [7:0] gr, input int hold);
        drive(rs, rd, gr, hold > S);
        hold_check(hold);
    endtask

    task automatic row(input int r, input logic [7:0] g, input int hold);
        step(8'(~(8'h1 << r)), 8'(8'h1 << r), g, hold);
    endtask

    task automatic frame(input logic [7:0] g);
        for (int r = 0; r < 8; r++) row(r, g, 10);
    endtask

    task automatic do_reset;
        #2;
        reset = 0;
        bus.row_sink = 8'hFF; bus.red_driver = 8'h0; bus.green_driver = 8'h0;
        #1;
        check("reset arrays", {red_array ^ green_array} | red_array, 64'h0);
        check("reset green", green_array, 64'h0);
        check("reset pulses", 64'({frame_valid, seq_error}), 64'h0);
        check("reset link_lost", 64'(link_lost), 64'h0);
        check("reset frame_count", 64'(frame_count), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        model_reset;
    endtask

    initial begin
        logic [7:0] rs, rd, gr;
        int kind, hold, lost_at;
        bus.row_sink = 8'hFF; bus.red_driver = 8'h0; bus.green_driver = 8'h0;
        m_fv = 0; m_se = 0;
        #1;
        do_reset;
        hold_check(3);

        // clean frame with exact commit latency on row 7
        for (int r = 0; r < 7; r++) row(r, 8'hA5, 10);
        drive(8'h7F, 8'h80, 8'hA5, 1);
        repeat (S + 2) @(posedge clk);
        #1 check("fv before latency", 64'(frame_valid), 64'h0);
        @(posedge clk);
        #1 check("fv at latency", 64'(frame_valid), 64'h1);
        @(posedge clk);
        #1 check("fv one cycle", 64'(frame_valid), 64'h0);
        hold_check(10 - S - 4);
        check("diagonal red", red_array, 64'h8040201008040201);
        check("green A5", green_array, {8{8'hA5}});
        check("first count", 64'(frame_count), 64'h1);

        // short glitch on row 3
        do_reset;
        for (int r = 0; r < 3; r++) row(r, 8'h11, 10);
        row(3, 8'h11, S - 1);
        for (int r = 4; r < 8; r++) row(r, 8'h11, 10);
        check("glitch no frame", 64'(frame_count), 64'h0);
        frame(8'h22);
        check("after glitch count", 64'(frame_count), 64'h1);

        // malformed row while collecting, then timeout under blanking
        row(0, 8'h33, 10);
        row(1, 8'h33, 10);
        step(8'b1111_0011, 8'h5A, 8'h5A, 10);
        row(2, 8'h33, 10);
        drive(8'hFF, 8'h0, 8'h0, 1);
        lost_at = last_ev + T;
        repeat (lost_at - 1 - cyc) @(posedge clk);
        #1 check("link_lost early", 64'(link_lost), 64'h0);
        @(posedge clk);
        #1 check("link_lost at timeout", 64'(link_lost), 64'h1);
        hold_check(3);
        row(0, 8'h44, 10);
        check("link restored", 64'(link_lost), 64'h0);

        // restart mid-frame, then counter wrap
        do_reset;
        for (int r = 0; r < 3; r++) row(r, 8'h11, 10);
        frame(8'h3C);
        check("restart count", 64'(frame_count), 64'h1);
        check("restart green", green_array, {8{8'h3C}});
        do_reset;
        for (int f = 0; f < 5; f++) begin
            frame(8'(f * 17 + 3));
            check("wrap count", 64'(frame_count), 64'(wrap_exp[f]));
        end

        // reset mid-frame
        for (int r = 0; r < 5; r++) row(r, 8'h66, 10);
        do_reset;
        hold_check(4);
        frame(8'h77);

        // random scan traffic
        for (int k = 0; k < 80; k++) begin
            kind = $urandom_range(0, 9);
            rd = 8'($urandom);
            gr = 8'($urandom);
            hold = $urandom_range(8, 12);
            rs = 8'(~(8'h1 << (got > 0 ? got : 0)));
            if (kind == 5) rs = 8'(~(8'h1 << $urandom_range(0, 7)));
            if (kind == 6) rs = 8'hFE;
            if (kind == 7) begin
                rs = 8'($urandom);
                while ($countones(~rs) < 2) rs = 8'($urandom);
            end
            if (kind == 8) rs = 8'hFF;
            if (kind == 9) begin
                rs = 8'(~(8'h1 << $urandom_range(0, 7)));
                hold = $urandom_range(1, S - 1);
            end
            if ({rs, rd, gr} == last_pat) rd = ~rd;
            step(rs, rd, gr, hold);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/led_matrix_capture.md
Name: led_matrix_capture

Overview:
- Receive-side counterpart of the 8x8 bicolour LED matrix scan interface: samples row_sink / red_driver / green_driver, as driven onto GPIO, and rebuilds the full red and green frame arrays.
- Used as an in-system scan monitor and as the input stage of a second board that mirrors the game display.
- Frames are committed atomically, so downstream logic always sees a complete, coherent 8x8 image.

Parameters:
- STABLE_CYCLES, 4, consecutive equal samples needed to accept a row (legal range 1..255).
- TIMEOUT_CYCLES, 4096, cycles without an accepted row before link_lost is raised.
- CNT_W, 16, width of frame_count.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- row_sink  input  8  scan row select; active-low one-hot; bit r low = row r driven; all-ones = blanking.
- red_driver  input  8  red column data for the selected row; bit c = column c; active-high.
- green_driver  input  8  green column data for the selected row; same encoding as red_driver.
- red_array  output  [7:0][7:0]  committed red frame; red_array[r][c].
- green_array  output  [7:0][7:0]  committed green frame.
- frame_valid  output  1  one-cycle pulse when a new frame is committed.
- seq_error  output  1  one-cycle pulse on a malformed or out-of-order row.
- link_lost  output  1  level; high when no row has been accepted for TIMEOUT_CYCLES.
- frame_count  output  CNT_W  count of committed frames; wraps to 0.

Behaviour:
- Reset values: red_array = 0, green_array = 0, frame_valid = 0, seq_error = 0, link_lost = 0, frame_count = 0, state = HUNT, shadow buffer = 0, expected row = 0.
- Synchroniser: all 24 input bits pass through a 2-flop synchroniser before any use.
- Stability filter: a stable counter increments each cycle the synchronised 24-bit sample equals the previous cycle's sample. Any difference clears it to 0.
- Sample event: fires for exactly one cycle when the counter reaches STABLE_CYCLES; it fires once per stable period.
- Latency: the event occurs STABLE_CYCLES+2 clocks after a pin change.
- Event classification:
  - row_sink all-ones: blanking; ignored; the timeout counter is not cleared.
  - row_sink with exactly one 0 bit: row event with index r.
  - anything else: malformed; seq_error pulses and the FSM goes to HUNT.
- Row event effects: shadow_red[r] <= red, shadow_green[r] <= green, timeout counter cleared, link_lost <= 0. The FSM then acts as follows.
- FSM state HUNT:
  - Row event with r == 0: write shadow row 0, expected <= 1, go to COLLECT.
  - Row event with any other r: ignored, with no seq_error.
- FSM state COLLECT:
  - Row event with r == expected and r < 7: expected <= expected+1.
  - Row event with r == expected == 7: on the next clock, both arrays <= the full shadow (including row 7), frame_valid pulses, frame_count increments, expected <= 0; the FSM stays in COLLECT.
  - Row event with r != expected: seq_error pulses; the partial frame is discarded. If r == 0, restart the frame (write row 0, expected <= 1, stay in COLLECT); otherwise go to HUNT.
- Timeout:
  - A saturating counter increments every cycle with no row event.
  - On reaching TIMEOUT_CYCLES: link_lost <= 1, FSM goes to HUNT, and the partial frame is discarded.
  - Committed arrays hold their last value.
- Simultaneous timeout and row event in the same cycle: the row event wins; the counter is cleared and link_lost stays 0.
- frame_count: wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-frame: all state returns to its reset values immediately (asynchronously); the partial shadow is lost.

Test Plan:
1. Clean frame: after reset, drive rows 0..7 in order, each held for 10 clocks, with red row r = 8'h01<<r and green = 8'hA5 -> one frame_valid pulse at STABLE_CYCLES+3 clocks after the row-7 pin change; red_array is the identity diagonal; every green_array row = 8'hA5; frame_count = 1.
2. Short glitch: hold row 3 for only STABLE_CYCLES-1 clocks within an otherwise clean frame -> row 3 is not accepted, the next row (4) raises seq_error, FSM goes to HUNT, no frame_valid; the following clean frame commits with frame_count = 1.
3. Malformed row: row_sink = 8'b1111_0011 stable for 10 clocks in COLLECT -> one seq_error pulse; FSM in HUNT; arrays unchanged.
4. Blanking and timeout: row_sink = 8'hFF held for TIMEOUT_CYCLES clocks -> link_lost = 1 exactly TIMEOUT_CYCLES cycles after the last row event. A subsequent row 0 event clears link_lost to 0.
5. Restart and counter wrap:
   - Rows 0,1,2 then 0..7 -> one seq_error at the second row 0, then a single frame_valid containing only the second pass.
   - With CNT_W = 2, five clean frames -> frame_count sequence 1,2,3,0,1.
6. Reset mid-frame: pull reset low after rows 0..4 of frame 2 -> arrays = 0, frame_count = 0, no frame_valid. After release, a full frame commits normally.
